// File: rtl/fetch_mem_arbiter_if.sv
// ============================================================================
// fetch_mem_arbiter_if : requester-side and memory-side bus bundle for the
//                        I/D physical memory arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface fetch_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
);
    // I-side requester
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    // D-side requester
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    // Physical memory port
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_addr;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport master (
        input  i_read, i_addr,
        output i_rdata, i_resp,
        input  d_read, d_write, d_addr, d_wdata,
        output d_rdata, d_resp,
        output pmem_read, pmem_write, pmem_addr, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport slave (
        output i_read, i_addr,
        input  i_rdata, i_resp,
        output d_read, d_write, d_addr, d_wdata,
        input  d_rdata, d_resp,
        input  pmem_read, pmem_write, pmem_addr, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

`default_nettype wire

// File: rtl/fetch_mem_arbiter.sv
// ============================================================================
// fetch_mem_arbiter : shares one physical memory port between the I-side and
//                     D-side miss paths. Optional macro FETCH_ARB_RR_EN
//                     selects round-robin on contention (default: D priority).
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  wire logic             clk,
    input  wire logic             reset,
    fetch_mem_arbiter_if.master   bus
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT_I = 2'd1;
    localparam logic [1:0] S_GRANT_D = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic              d_req;
    logic              pick_d;

    assign d_req = bus.d_read | bus.d_write;

`ifdef FETCH_ARB_RR_EN
    // last_d_q=1 means D was served last; its reset value lets I win the first tie
    logic last_d_q, last_d_d;

    always_comb begin
        pick_d   = d_req && !(bus.i_read && last_d_q);
        last_d_d = last_d_q;
        if (bus.pmem_resp) begin
            if (state_q == S_GRANT_I) last_d_d = 1'b0;
            if (state_q == S_GRANT_D) last_d_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) last_d_q <= 1'b1;
        else       last_d_q <= last_d_d;
    end
`else
    always_comb begin
        pick_d = d_req;
    end
`endif

    // State and transaction latches
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
        end
    end

    // Next state: latches are only loaded on the grant edge and then held
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        case (state_q)
            S_IDLE: begin
                if (pick_d) begin
                    state_d = S_GRANT_D;
                    addr_d  = bus.d_addr;
                    wdata_d = bus.d_wdata;
                    write_d = bus.d_write;
                end else if (bus.i_read) begin
                    state_d = S_GRANT_I;
                    addr_d  = bus.i_addr;
                    wdata_d = '0;
                    write_d = 1'b0;
                end
            end
            S_GRANT_I, S_GRANT_D: begin
                if (bus.pmem_resp) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs from state and latched command only
    always_comb begin
        bus.pmem_read  = 1'b0;
        bus.pmem_write = 1'b0;
        bus.i_resp     = 1'b0;
        bus.d_resp     = 1'b0;
        case (state_q)
            S_GRANT_I: begin
                bus.pmem_read = 1'b1;
                bus.i_resp    = bus.pmem_resp;
            end
            S_GRANT_D: begin
                bus.pmem_read  = ~write_q;
                bus.pmem_write = write_q;
                bus.d_resp     = bus.pmem_resp;
            end
            default: ;
        endcase
    end

    assign bus.pmem_addr  = addr_q;
    assign bus.pmem_wdata = wdata_q;
    assign bus.i_rdata    = bus.pmem_rdata;
    assign bus.d_rdata    = bus.pmem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_fetch_mem_arbiter.sv
// ============================================================================
// tb_fetch_mem_arbiter : directed and randomized transaction-level checks of
//                        fetch_mem_arbiter (honours FETCH_ARB_RR_EN if set).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_mem_arbiter;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    bit   last_was_d;   // arbitration history, reset means "D served last"

    fetch_mem_arbiter_if #(.ADDR_W(16), .LINE_W(128)) bus ();

    fetch_mem_arbiter #(.ADDR_W(16), .LINE_W(128)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Winner of an IDLE-cycle decision: 1 = I-side, 2 = D-side
    function automatic int winner(input bit ir, input bit dq);
        if (!ir) return 2;
        if (!dq) return 1;
`ifdef FETCH_ARB_RR_EN
        return last_was_d ? 1 : 2;
`else
        return 2;
`endif
    endfunction

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_rd"},    bus.pmem_read,  1'b0);
        check({tag, "_wr"},    bus.pmem_write, 1'b0);
        check({tag, "_iresp"}, bus.i_resp,     1'b0);
        check({tag, "_dresp"}, bus.d_resp,     1'b0);
    endtask

    // Serve one transaction with requests already driven; drop_mask bit0=I, bit1=D
    task automatic serve_one(input int side, input logic [15:0] eaddr, input bit ewr,
                             input logic [127:0] ewd, input int lat, input bit [1:0] drop_mask);
        bit found;
        logic [127:0] rd;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (bus.pmem_read || bus.pmem_write) found = 1'b1;
        end
        check("grant_seen", found, 1'b1);
        if (!found) return;
        for (int k = 0; k < lat; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                if (side == 1) bus.i_addr = 16'h0000;
                else begin bus.d_addr = 16'h0000; bus.d_wdata = ~ewd; end
                @(negedge clk);
            end
            check("hold_addr", bus.pmem_addr, eaddr);
            check("hold_rd",   bus.pmem_read,  (side == 1) || !ewr);
            check("hold_wr",   bus.pmem_write, (side == 2) && ewr);
            if (side == 2 && ewr) check("hold_wdata", bus.pmem_wdata, ewd);
            check("hold_noresp", bus.i_resp | bus.d_resp, 1'b0);
        end
        @(posedge clk); #1;
        rd = rand_line();
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = rd;
        @(negedge clk);
        check("i_resp", bus.i_resp, side == 1);
        check("d_resp", bus.d_resp, side == 2);
        check("rdata", (side == 1) ? bus.i_rdata : bus.d_rdata, rd);
        last_was_d = (side == 2);
        @(posedge clk); #1;
        bus.pmem_resp = 1'b0;
        if (drop_mask[0]) bus.i_read = 1'b0;
        if (drop_mask[1]) begin bus.d_read = 1'b0; bus.d_write = 1'b0; end
        @(negedge clk);
        check_idle("post_idle");
    endtask

    initial begin
        logic [127:0] wd;
        logic [15:0]  ia, da;
        bit ir, dr, dw;
        int w;
        errors = 0; checks = 0; last_was_d = 1'b1;
        reset = 1'b1;
        bus.i_read = 1'b0; bus.i_addr = '0;
        bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.pmem_rdata = '0; bus.pmem_resp = 1'b0;

        // Reset values
        @(negedge clk);
        check_idle("rst");
        check("rst_addr",  bus.pmem_addr,  16'h0);
        check("rst_wdata", bus.pmem_wdata, 128'h0);
        @(posedge clk); #1 reset = 1'b0;

        // Reset during a D write: command and address drop immediately
        bus.d_write = 1'b1; bus.d_addr = 16'h1230; bus.d_wdata = rand_line();
        @(posedge clk); @(negedge clk);
        check("mid_wr_before", bus.pmem_write, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1; bus.d_write = 1'b0;
        #1;
        check("mid_rst_wr",   bus.pmem_write, 1'b0);
        check("mid_rst_addr", bus.pmem_addr,  16'h0);
        last_was_d = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; bus.pmem_resp = 1'b1;
        @(negedge clk);
        check_idle("after_rst");
        @(posedge clk); #1 bus.pmem_resp = 1'b0;
        @(negedge clk);
        check_idle("after_rst2");

        // Both sides requesting continuously for 4 transactions
        @(posedge clk); #1;
        bus.i_read = 1'b1; bus.i_addr = 16'h0A00;
        bus.d_read = 1'b1; bus.d_addr = 16'h0B00;
        for (int k = 0; k < 4; k++) begin
            w = winner(1'b1, 1'b1);
            serve_one(w, (w == 1) ? 16'h0A00 : 16'h0B00, 1'b0, '0, 2, (k == 3) ? 2'b11 : 2'b00);
            bus.i_addr = 16'h0A00; bus.d_addr = 16'h0B00;
        end

        // Lone I read, latency 4; command appears the cycle after the request
        @(posedge clk); #1;
        bus.i_read = 1'b1; bus.i_addr = 16'h0040;
        @(negedge clk);
        check("i_req_cycle_rd", bus.pmem_read, 1'b0);
        serve_one(1, 16'h0040, 1'b0, '0, 4, 2'b01);

        // Simultaneous I 0x0100 and D 0x2000
        @(posedge clk); #1;
        bus.i_read = 1'b1; bus.i_addr = 16'h0100;
        bus.d_read = 1'b1; bus.d_addr = 16'h2000;
        w = winner(1'b1, 1'b1);
        serve_one(w, (w == 1) ? 16'h0100 : 16'h2000, 1'b0, '0, 3, (w == 1) ? 2'b01 : 2'b10);
        bus.i_addr = 16'h0100; bus.d_addr = 16'h2000;
        serve_one(3 - w, (w == 1) ? 16'h2000 : 16'h0100, 1'b0, '0, 2, 2'b11);

        // D write to 0x3FF0 with d_addr moved to 0 mid-transaction
        @(posedge clk); #1;
        wd = 128'hBEEF_0000_0000_0000_0000_0000_0000_0001;
        bus.d_write = 1'b1; bus.d_addr = 16'h3FF0; bus.d_wdata = wd;
        serve_one(2, 16'h3FF0, 1'b1, wd, 4, 2'b10);

        // Stray pmem_resp in IDLE
        @(posedge clk); #1 bus.pmem_resp = 1'b1;
        @(negedge clk);
        check_idle("stray");
        @(posedge clk); #1 bus.pmem_resp = 1'b0;
        @(negedge clk);
        check_idle("stray2");

        // Read and write both high: write wins
        @(posedge clk); #1;
        wd = rand_line();
        bus.d_read = 1'b1; bus.d_write = 1'b1; bus.d_addr = 16'h5A5A; bus.d_wdata = wd;
        serve_one(2, 16'h5A5A, 1'b1, wd, 2, 2'b10);

        // Randomized rounds
        for (int r = 0; r < 24; r++) begin
            ir = 1'($urandom_range(0, 1)); dr = 1'($urandom_range(0, 1)); dw = 1'($urandom_range(0, 1));
            if (!ir && !dr && !dw) ir = 1'b1;
            ia = 16'($urandom); da = 16'($urandom);
            if (ia == da) da = ~ia;
            wd = rand_line();
            @(posedge clk); #1;
            bus.i_read = ir; bus.i_addr = ia;
            bus.d_read = dr; bus.d_write = dw; bus.d_addr = da; bus.d_wdata = wd;
            w = winner(ir, dr | dw);
            serve_one(w, (w == 1) ? ia : da, (w == 2) && dw, wd, $urandom_range(1, 5),
                      (w == 1) ? 2'b01 : 2'b10);
            if (w == 1 && (dr || dw))
                serve_one(2, da, dw, wd, $urandom_range(1, 5), 2'b10);
            else if (w == 2 && ir)
                serve_one(1, ia, 1'b0, '0, $urandom_range(1, 5), 2'b01);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
